// File: rtl/sha256_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// sha256_round_ctrl_if
//   Bundles every non-clock/reset signal of the SHA-256 round controller:
//   the upstream start/busy handshake, the downstream valid/ready handshake,
//   the round-counter clear/enable/index lines and the datapath strobes.
//   Signal names keep the controller's point of view (i_ = into controller,
//   o_ = out of controller).
//
//   Modports:
//     slave  - the controller itself (sha256_round_ctrl)
//     master - the surrounding system (counter, datapath, host)
// -----------------------------------------------------------------------------
interface sha256_round_ctrl_if;
    // Upstream handshake
    logic       i_start;
    logic       i_first;
    logic       i_abort;
    logic       o_busy;
    // Downstream handshake
    logic       i_ready;
    logic       o_valid;
    // Round counter
    logic [7:0] i_round_idx;
    logic       o_clr_i;
    logic       o_cnt_i_en;
    // Datapath strobes
    logic       o_load_msg;
    logic       o_init_vars;
    logic       o_sel_iv;
    logic       o_w_sel;
    logic       o_round_en;
    logic       o_hash_upd;

    modport slave (
        input  i_start, i_first, i_abort, i_ready, i_round_idx,
        output o_busy, o_valid, o_clr_i, o_cnt_i_en, o_load_msg,
               o_init_vars, o_sel_iv, o_w_sel, o_round_en, o_hash_upd
    );

    modport master (
        output i_start, i_first, i_abort, i_ready, i_round_idx,
        input  o_busy, o_valid, o_clr_i, o_cnt_i_en, o_load_msg,
               o_init_vars, o_sel_iv, o_w_sel, o_round_en, o_hash_upd
    );
endinterface

// File: rtl/sha256_round_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_round_ctrl
//   Control FSM for one SHA-256 compression pass over a single 512-bit block.
//   Drives the external round-index counter (clear / count-enable) and reads
//   its index back to sequence NUM_ROUNDS rounds, then updates the hash and
//   presents the digest with a valid/ready handshake.
//
//   Ports:
//     i_clk  - clock, all state on rising edge
//     i_rst  - synchronous active-high reset
//     bus    - sha256_round_ctrl_if.slave (handshakes, counter, strobes)
//
//   Parameters:
//     NUM_ROUNDS - compression rounds (17..255)
//     MSG_WORDS  - leading rounds that use message words directly
// -----------------------------------------------------------------------------
module sha256_round_ctrl #(
    parameter int NUM_ROUNDS = 64,
    parameter int MSG_WORDS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sha256_round_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_UPDATE,
        S_OUTPUT
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_ROUNDS - 1);
    localparam logic [7:0] MSG_IDX  = 8'(MSG_WORDS);

    state_t r_state;
    state_t w_next;
    logic   r_sel_iv;
    logic   w_accept;

    // A start is only taken in IDLE, and an abort in the same cycle wins.
    assign w_accept = (r_state == S_IDLE) && bus.i_start && !bus.i_abort;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sel_iv <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel_iv <= bus.i_first;
            end
        end
    end

    // Next-state logic. Abort overrides every other transition.
    // NOTE: w_next gets a default before any branch so no latch is inferred.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_LOAD;
            S_LOAD:   w_next = S_ROUND;
            // >= so an out-of-range index from the counter still terminates.
            S_ROUND:  if (bus.i_round_idx >= LAST_IDX) w_next = S_UPDATE;
            S_UPDATE: w_next = S_OUTPUT;
            S_OUTPUT: if (bus.i_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (bus.i_abort) begin
            w_next = S_IDLE;
        end
    end

    // Moore output decode; only o_w_sel also looks at the counter index.
    always_comb begin
        bus.o_clr_i     = 1'b0;
        bus.o_cnt_i_en  = 1'b0;
        bus.o_load_msg  = 1'b0;
        bus.o_init_vars = 1'b0;
        bus.o_w_sel     = 1'b0;
        bus.o_round_en  = 1'b0;
        bus.o_hash_upd  = 1'b0;
        bus.o_valid     = 1'b0;
        bus.o_busy      = (r_state != S_IDLE);
        unique case (r_state)
            S_IDLE: begin
                bus.o_clr_i = 1'b1;
            end
            S_LOAD: begin
                bus.o_load_msg  = 1'b1;
                bus.o_init_vars = 1'b1;
                bus.o_clr_i     = 1'b1;
            end
            S_ROUND: begin
                bus.o_round_en = 1'b1;
                bus.o_cnt_i_en = 1'b1;
                bus.o_w_sel    = (bus.i_round_idx >= MSG_IDX);
            end
            S_UPDATE: begin
                // Counter sits at NUM_ROUNDS here; clearing it readies the
                // next block.
                bus.o_hash_upd = 1'b1;
                bus.o_clr_i    = 1'b1;
            end
            S_OUTPUT: begin
                bus.o_valid = 1'b1;
            end
            default: begin
                bus.o_clr_i = 1'b1;
            end
        endcase
    end

    assign bus.o_sel_iv = r_sel_iv;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sha256_round_ctrl
//   Directed bench for sha256_round_ctrl. The bench models the round-index
//   counter (clear wins over enable) and feeds its value back as i_round_idx;
//   an override lets a test inject an out-of-range index.
// -----------------------------------------------------------------------------
module tb_sha256_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha256_round_ctrl_if ifc ();

    sha256_round_ctrl #(
        .NUM_ROUNDS (64),
        .MSG_WORDS  (16)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc)
    );

    // Round-counter model
    logic [7:0] cnt     = 8'd0;
    logic       ovr_en  = 1'b0;
    logic [7:0] ovr_val = 8'd0;

    always @(posedge clk) begin
        if (ifc.o_clr_i)         cnt <= 8'd0;
        else if (ifc.o_cnt_i_en) cnt <= cnt + 8'd1;
    end

    assign ifc.i_round_idx = ovr_en ? ovr_val : cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All per-cycle strobes that must be quiet while holding in OUTPUT.
    function automatic logic [5:0] strobes();
        return {ifc.o_load_msg, ifc.o_init_vars, ifc.o_round_en,
                ifc.o_hash_upd, ifc.o_cnt_i_en, ifc.o_clr_i};
    endfunction

    // Runs one block from the current IDLE cycle and measures it. Cycle 1 is
    // the cycle after the edge that samples i_start. Returns on the first
    // o_valid cycle (without stepping past it) or after a 200-cycle budget.
    task automatic run_block(
        input  logic first_v,
        input  logic ready_v,
        input  bit   poke,
        output int   n_load,
        output int   n_round,
        output int   n_wsel_err,
        output int   n_sel_err,
        output int   n_overlap,
        output int   upd_cyc,
        output int   valid_cyc,
        output int   idx_at_valid
    );
        int   cyc;
        logic exp_w;
        n_load = 0; n_round = 0; n_wsel_err = 0; n_sel_err = 0; n_overlap = 0;
        upd_cyc = -1; valid_cyc = -1; idx_at_valid = -1;
        ifc.i_ready = ready_v;
        ifc.i_first = first_v;
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        ifc.i_first = 1'b0;
        cyc = 1;
        while (cyc < 200) begin
            if (poke) begin
                // Stray starts during ROUND, with i_first opposite to the run.
                ifc.i_start = (cyc == 10 || cyc == 40);
                ifc.i_first = ~first_v;
            end
            if (ifc.o_load_msg) n_load++;
            if (ifc.o_round_en) begin
                n_round++;
                exp_w = (ifc.i_round_idx >= 8'd16);
                if (ifc.o_w_sel !== exp_w) n_wsel_err++;
            end
            if (ifc.o_sel_iv !== first_v) n_sel_err++;
            if (ifc.o_clr_i && ifc.o_cnt_i_en) n_overlap++;
            if (ifc.o_hash_upd && upd_cyc < 0) upd_cyc = cyc;
            if (ifc.o_valid) begin
                valid_cyc    = cyc;
                idx_at_valid = int'(cnt);
                break;
            end
            step();
            cyc++;
        end
        ifc.i_start = 1'b0;
        ifc.i_first = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_tests++;
        if (ifc.o_clr_i !== 1'b1) begin
            $display("FAIL reset.clr_i: got %b expected 1", ifc.o_clr_i); n_fail++;
        end
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0) begin
            $display("FAIL reset.busy_valid: got busy=%b valid=%b expected 0/0",
                     ifc.o_busy, ifc.o_valid); n_fail++;
        end
        n_tests++;
        if ({ifc.o_load_msg, ifc.o_init_vars, ifc.o_round_en, ifc.o_hash_upd,
             ifc.o_cnt_i_en, ifc.o_w_sel, ifc.o_sel_iv} !== 7'b0) begin
            $display("FAIL reset.strobes: got load=%b init=%b rnd=%b upd=%b cnt=%b wsel=%b seliv=%b expected all 0",
                     ifc.o_load_msg, ifc.o_init_vars, ifc.o_round_en, ifc.o_hash_upd,
                     ifc.o_cnt_i_en, ifc.o_w_sel, ifc.o_sel_iv); n_fail++;
        end
        n_tests++;
        if (cnt !== 8'd0) begin
            $display("FAIL reset.counter: got %0d expected 0", cnt); n_fail++;
        end
    endtask

    task automatic test_single_block();
        int n_load, n_round, n_wsel_err, n_sel_err, n_overlap, upd_cyc, valid_cyc, idx_v;
        run_block(1'b1, 1'b1, 1'b0, n_load, n_round, n_wsel_err, n_sel_err,
                  n_overlap, upd_cyc, valid_cyc, idx_v);
        n_tests++;
        if (n_load !== 1) begin
            $display("FAIL single.load_cycles: got %0d expected 1", n_load); n_fail++;
        end
        n_tests++;
        if (n_round !== 64) begin
            $display("FAIL single.round_cycles: got %0d expected 64", n_round); n_fail++;
        end
        n_tests++;
        if (n_wsel_err !== 0) begin
            $display("FAIL single.w_sel: got %0d bad cycles expected 0", n_wsel_err); n_fail++;
        end
        n_tests++;
        if (n_sel_err !== 0) begin
            $display("FAIL single.sel_iv: got %0d cycles not 1 expected 0", n_sel_err); n_fail++;
        end
        n_tests++;
        if (n_overlap !== 0) begin
            $display("FAIL single.clr_cnt_overlap: got %0d expected 0", n_overlap); n_fail++;
        end
        n_tests++;
        if (upd_cyc !== 66) begin
            $display("FAIL single.hash_upd_cycle: got %0d expected 66", upd_cyc); n_fail++;
        end
        n_tests++;
        if (valid_cyc !== 67) begin
            $display("FAIL single.valid_cycle: got %0d expected 67", valid_cyc); n_fail++;
        end
        n_tests++;
        if (idx_v !== 0) begin
            $display("FAIL single.idx_after_update: got %0d expected 0", idx_v); n_fail++;
        end
        step();
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0 || ifc.o_sel_iv !== 1'b1) begin
            $display("FAIL single.back_to_idle: got busy=%b valid=%b sel_iv=%b expected 0/0/1",
                     ifc.o_busy, ifc.o_valid, ifc.o_sel_iv); n_fail++;
        end
    endtask

    // Starts in the first IDLE cycle after the previous handshake.
    task automatic test_back_to_back();
        int n_load, n_round, n_wsel_err, n_sel_err, n_overlap, upd_cyc, valid_cyc, idx_v;
        run_block(1'b0, 1'b1, 1'b1, n_load, n_round, n_wsel_err, n_sel_err,
                  n_overlap, upd_cyc, valid_cyc, idx_v);
        n_tests++;
        if (n_sel_err !== 0) begin
            $display("FAIL chained.sel_iv: got %0d cycles not 0 expected 0", n_sel_err); n_fail++;
        end
        n_tests++;
        if (n_load !== 1 || n_round !== 64) begin
            $display("FAIL chained.load_round: got load=%0d rounds=%0d expected 1/64",
                     n_load, n_round); n_fail++;
        end
        n_tests++;
        if (upd_cyc !== 66 || valid_cyc !== 67) begin
            $display("FAIL chained.timing: got upd=%0d valid=%0d expected 66/67",
                     upd_cyc, valid_cyc); n_fail++;
        end
        n_tests++;
        if (n_wsel_err !== 0) begin
            $display("FAIL chained.w_sel: got %0d bad cycles expected 0", n_wsel_err); n_fail++;
        end
        step();
        n_tests++;
        if (ifc.o_busy !== 1'b0) begin
            $display("FAIL chained.back_to_idle: got busy=%b expected 0", ifc.o_busy); n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int n_load, n_round, n_wsel_err, n_sel_err, n_overlap, upd_cyc, valid_cyc, idx_v;
        int n_hold_err;
        run_block(1'b1, 1'b0, 1'b0, n_load, n_round, n_wsel_err, n_sel_err,
                  n_overlap, upd_cyc, valid_cyc, idx_v);
        n_tests++;
        if (valid_cyc !== 67) begin
            $display("FAIL bp.valid_cycle: got %0d expected 67", valid_cyc); n_fail++;
        end
        n_hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.o_valid !== 1'b1 || ifc.o_busy !== 1'b1 || strobes() !== 6'b0)
                n_hold_err++;
        end
        n_tests++;
        if (n_hold_err !== 0) begin
            $display("FAIL bp.hold: got %0d bad cycles expected 0", n_hold_err); n_fail++;
        end
        ifc.i_ready = 1'b1;
        step();
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0 || ifc.o_clr_i !== 1'b1) begin
            $display("FAIL bp.release: got busy=%b valid=%b clr=%b expected 0/0/1",
                     ifc.o_busy, ifc.o_valid, ifc.o_clr_i); n_fail++;
        end
    endtask

    task automatic test_abort();
        int n_load, n_round, n_wsel_err, n_sel_err, n_overlap, upd_cyc, valid_cyc, idx_v;
        int guard;
        int n_bad;
        ifc.i_ready = 1'b1;
        ifc.i_first = 1'b1;
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        ifc.i_first = 1'b0;
        guard = 0;
        while (!(ifc.o_round_en === 1'b1 && cnt == 8'd30) && guard < 100) begin
            step();
            guard++;
        end
        n_tests++;
        if (guard >= 100) begin
            $display("FAIL abort.reach_idx30: got timeout expected ROUND at idx 30"); n_fail++;
        end
        ifc.i_abort = 1'b1;
        step();
        ifc.i_abort = 1'b0;
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_valid !== 1'b0 || ifc.o_hash_upd !== 1'b0 ||
            ifc.o_clr_i !== 1'b1) begin
            $display("FAIL abort.idle: got busy=%b valid=%b upd=%b clr=%b expected 0/0/0/1",
                     ifc.o_busy, ifc.o_valid, ifc.o_hash_upd, ifc.o_clr_i); n_fail++;
        end
        step();
        n_tests++;
        if (cnt !== 8'd0) begin
            $display("FAIL abort.counter: got %0d expected 0", cnt); n_fail++;
        end
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (ifc.o_hash_upd || ifc.o_valid || ifc.o_busy) n_bad++;
            step();
        end
        n_tests++;
        if (n_bad !== 0) begin
            $display("FAIL abort.quiet: got %0d active cycles expected 0", n_bad); n_fail++;
        end
        // Start and abort together in IDLE: abort wins, i_first not latched.
        ifc.i_first = 1'b0;
        ifc.i_start = 1'b1;
        ifc.i_abort = 1'b1;
        step();
        ifc.i_start = 1'b0;
        ifc.i_abort = 1'b0;
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_sel_iv !== 1'b1) begin
            $display("FAIL abort.start_with_abort: got busy=%b sel_iv=%b expected 0/1",
                     ifc.o_busy, ifc.o_sel_iv); n_fail++;
        end
        run_block(1'b1, 1'b1, 1'b0, n_load, n_round, n_wsel_err, n_sel_err,
                  n_overlap, upd_cyc, valid_cyc, idx_v);
        n_tests++;
        if (n_round !== 64 || valid_cyc !== 67) begin
            $display("FAIL abort.rerun: got rounds=%0d valid=%0d expected 64/67",
                     n_round, valid_cyc); n_fail++;
        end
        step();
    endtask

    task automatic test_out_of_range();
        ifc.i_ready = 1'b1;
        ifc.i_first = 1'b1;
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        step();
        ovr_en  = 1'b1;
        ovr_val = 8'd200;
        #1;
        n_tests++;
        if (ifc.o_round_en !== 1'b1 || ifc.o_w_sel !== 1'b1) begin
            $display("FAIL oor.round: got round_en=%b w_sel=%b expected 1/1",
                     ifc.o_round_en, ifc.o_w_sel); n_fail++;
        end
        step();
        ovr_en = 1'b0;
        n_tests++;
        if (ifc.o_hash_upd !== 1'b1) begin
            $display("FAIL oor.terminate: got hash_upd=%b expected 1", ifc.o_hash_upd); n_fail++;
        end
        step();
        n_tests++;
        if (ifc.o_valid !== 1'b1) begin
            $display("FAIL oor.valid: got %b expected 1", ifc.o_valid); n_fail++;
        end
        step();
    endtask

    task automatic test_reset_mid();
        int guard;
        int n_bad;
        ifc.i_ready = 1'b1;
        ifc.i_first = 1'b1;
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
        ifc.i_first = 1'b0;
        guard = 0;
        while (!(ifc.o_round_en === 1'b1 && cnt == 8'd50) && guard < 100) begin
            step();
            guard++;
        end
        n_tests++;
        if (guard >= 100) begin
            $display("FAIL rstmid.reach_idx50: got timeout expected ROUND at idx 50"); n_fail++;
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (ifc.o_busy !== 1'b0 || ifc.o_cnt_i_en !== 1'b0 || ifc.o_clr_i !== 1'b1 ||
            ifc.o_hash_upd !== 1'b0 || ifc.o_sel_iv !== 1'b0) begin
            $display("FAIL rstmid.idle: got busy=%b cnt_en=%b clr=%b upd=%b sel_iv=%b expected 0/0/1/0/0",
                     ifc.o_busy, ifc.o_cnt_i_en, ifc.o_clr_i, ifc.o_hash_upd, ifc.o_sel_iv); n_fail++;
        end
        rst = 1'b0;
        n_bad = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (ifc.o_hash_upd || ifc.o_valid || ifc.o_busy) n_bad++;
        end
        n_tests++;
        if (n_bad !== 0) begin
            $display("FAIL rstmid.quiet: got %0d active cycles expected 0", n_bad); n_fail++;
        end
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifc.i_start = 1'b0;
        ifc.i_first = 1'b0;
        ifc.i_abort = 1'b0;
        ifc.i_ready = 1'b1;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_out_of_range();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
